sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Parametrised N-client arbiter between pixel-path controllers (pixel writer, pixel reader, future clients) and the single SRAM controller, replacing the hard-wired two-way select mux. It arbitrates among pending requests itself (round-robin or fixed priority), registers and holds the winning command for the whole SRAM transaction, and routes completion and read data back only to the granted client. A watchdog aborts transactions the SRAM controller never completes.

## Interface
Parameters:
- NUM_CLIENTS, 2, number of requesters (2..8).
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = lowest index always wins.
- TIMEOUT, 255, max WAIT cycles before abort (1..65535).

Ports (client i occupies slice [i*W +: W] of flattened buses):
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- req_start  in  NUM_CLIENTS  per-client request, level, held until that client's req_ready.
- req_rw  in  NUM_CLIENTS  1 = read, 0 = write.
- req_addr  in  NUM_CLIENTS*ADDR_W  request addresses.
- req_wdata  in  NUM_CLIENTS*DATA_W  write data.
- req_ready  out  NUM_CLIENTS  one-cycle completion pulse to granted client.
- req_err  out  NUM_CLIENTS  high with req_ready when transaction timed out.
- req_rdata  out  NUM_CLIENTS*DATA_W  per-client registered read data.
- sram_start  out  1  one-cycle command strobe to SRAM controller.
- sram_rw, sram_addr, sram_data  out  1/ADDR_W/DATA_W  registered command.
- sram_data_out  in  DATA_W  read data from SRAM controller.
- sram_ready  in  1  completion pulse from SRAM controller.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req_start set, choose grant g, latch req_rw/addr/wdata of g into sram_* registers, -> ISSUE. Else stay.
- Round-robin: search starts at last_grant+1, wraps modulo NUM_CLIENTS; last_grant updated on entering DONE. Reset last_grant = NUM_CLIENTS-1 (client 0 first).
- FIXED_PRIORITY=1: lowest-index pending client wins; last_grant ignored.
- ISSUE: sram_start = 1 for exactly this cycle; clear timeout counter; -> WAIT.
- WAIT: sram_ready sampled only here. sram_ready=1 -> DONE; on read, req_rdata[g] <= sram_data_out. Counter reaching TIMEOUT with no sram_ready -> DONE with error flag; req_rdata[g] unchanged.
- DONE: req_ready[g] = 1 (req_err[g] = 1 if aborted) for one cycle; -> IDLE.
- sram_rw/addr/data hold stable from ISSUE through DONE; change only on next IDLE grant.
- Non-granted clients' req_rdata hold; writes never modify req_rdata.
- Changes to a granted client's req_* inputs after grant are ignored.

## Timing
- Reset (async): state IDLE, all outputs 0, req_rdata all 0, counter 0, last_grant = NUM_CLIENTS-1. Reset mid-transaction abandons it: no req_ready issued.
- Minimum latency: req_start seen at edge 0 -> sram_start high cycle 1 -> sram_ready high cycle 2 -> req_ready high cycle 3. Back-to-back throughput: one transaction per 4 cycles minimum.
- Client rule: deassert req_start in cycle after sampling req_ready; arbiter re-samples requests in IDLE, so a still-held start is a new transaction.
- sram_ready outside WAIT is ignored (no spurious completions).
- Timeout: sram_ready arriving in the same cycle the counter reaches TIMEOUT counts as success.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Single read, client 1, addr 0x0040, sram_ready 3 cycles after sram_start, sram_data_out 0xBEEF -> sram_addr 0x0040 rw=1, req_ready[1] one pulse, req_rdata[1]=0xBEEF, req_rdata[0] unchanged.
- NUM_CLIENTS=4 round-robin, all four req_start held continuously -> grant order 0,1,2,3,0; sram_start spacing ≥ 4 cycles.
- FIXED_PRIORITY=1, clients 0 and 2 held -> client 0 granted every time; client 2 starves, no req_ready[2].
- TIMEOUT=8, sram_ready never asserted -> req_ready[g] and req_err[g] pulse 9 cycles after sram_start cycle, req_rdata[g] unchanged; next request served normally.
- Stray sram_ready while IDLE, then write of 0x1234 to 0x00FF by client 0 -> no req_ready from stray; write completes only on in-WAIT sram_ready, req_rdata[0] unchanged.
- rst asserted during WAIT -> all outputs 0 immediately, no req_ready; after release client 0 granted first.

Source files
------------

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares the single SRAM controller between NUM_CLIENTS pixel-path clients
// (pixel writer, pixel reader, ...). One transaction at a time:
//   IDLE  : pick a winner among pending requests and latch its command
//   ISSUE : one-cycle sram_start strobe
//   WAIT  : wait for sram_ready, or abort after TIMEOUT cycles
//   DONE  : one-cycle req_ready (plus req_err on abort) to the winner only
//
// Arbitration is round-robin (starting after the last served client) or,
// with FIXED_PRIORITY=1, lowest index wins. Every output is a flop, so there
// is no combinational path from any input to any output.
//
// Ports (client i uses slice [i*W +: W] of the flattened buses):
//   clk, rst       clock and asynchronous active-high reset
//   req_start      per-client request level, held until req_ready
//   req_rw         per-client direction, 1 = read, 0 = write
//   req_addr       per-client address
//   req_wdata      per-client write data
//   req_ready      one-cycle completion pulse to the granted client
//   req_err        high together with req_ready when the transaction timed out
//   req_rdata      per-client registered read data
//   sram_start     one-cycle command strobe to the SRAM controller
//   sram_rw        registered command direction
//   sram_addr      registered command address
//   sram_data      registered command write data
//   sram_data_out  read data from the SRAM controller
//   sram_ready     completion pulse from the SRAM controller
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int NUM_CLIENTS    = 2,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT        = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS-1:0]        req_start,
    input  logic [NUM_CLIENTS-1:0]        req_rw,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] req_wdata,
    output logic [NUM_CLIENTS-1:0]        req_ready,
    output logic [NUM_CLIENTS-1:0]        req_err,
    output logic [NUM_CLIENTS*DATA_W-1:0] req_rdata,
    output logic                          sram_start,
    output logic                          sram_rw,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic [DATA_W-1:0]             sram_data,
    input  logic [DATA_W-1:0]             sram_data_out,
    input  logic                          sram_ready
);

    localparam int              GW        = $clog2(NUM_CLIENTS);
    // WAIT lasts at most TIMEOUT cycles: the counter runs 0..TIMEOUT-1.
    localparam logic [15:0]     TO_LAST   = 16'(TIMEOUT - 1);
    // Round-robin pointer starts at the top so client 0 is served first.
    localparam logic [GW-1:0]   LAST_INIT = GW'(NUM_CLIENTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   state_q;
    state_t                   state_d;

    logic [GW-1:0]            grant_q;
    logic [GW-1:0]            last_grant_q;
    logic [15:0]              cnt_q;
    logic [15:0]              cnt_d;

    logic                     sram_start_q;
    logic                     sram_start_d;
    logic                     sram_rw_q;
    logic [ADDR_W-1:0]        sram_addr_q;
    logic [DATA_W-1:0]        sram_data_q;
    logic [NUM_CLIENTS-1:0]   req_ready_q;
    logic [NUM_CLIENTS-1:0]   req_ready_d;
    logic [NUM_CLIENTS-1:0]   req_err_q;
    logic [NUM_CLIENTS-1:0]   req_err_d;

    logic                     pick_valid;
    logic [GW-1:0]            pick_idx;
    int                       cand;

    logic                     load_cmd;
    logic                     enter_done;
    logic                     rdata_we;

    logic [ADDR_W-1:0]        addr_arr  [NUM_CLIENTS];
    logic [DATA_W-1:0]        wdata_arr [NUM_CLIENTS];

    // -------------------------------------------------------------------------
    // Per-client slicing of the flattened buses and per-client read-data
    // registers. A client's read data only changes when it is the granted
    // client and its read completed successfully.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
            logic [DATA_W-1:0] rdata_q;

            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
            assign req_rdata[gi*DATA_W +: DATA_W] = rdata_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (rdata_we && (grant_q == GW'(gi))) begin
                    rdata_q <= sram_data_out;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Winner selection. Candidates are scanned from lowest to highest
    // priority so the final assignment is the highest-priority pending one.
    // -------------------------------------------------------------------------
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        if (FIXED_PRIORITY != 0) begin
            for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
                if (req_start[GW'(i)]) begin
                    pick_valid = 1'b1;
                    pick_idx   = GW'(i);
                end
            end
        end else begin
            // Offset 1 (the client right after the last one served) is the
            // most favoured, offset NUM_CLIENTS (the last one served) the least.
            for (int off = NUM_CLIENTS; off >= 1; off--) begin
                cand = int'(last_grant_q) + off;
                if (cand >= NUM_CLIENTS) begin
                    cand = cand - NUM_CLIENTS;
                end
                if (req_start[GW'(cand)]) begin
                    pick_valid = 1'b1;
                    pick_idx   = GW'(cand);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state. sram_ready is only looked at in WAIT, so a stray pulse
    // in any other state is simply dropped. A ready arriving on the last
    // allowed WAIT cycle still wins over the timeout.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (pick_valid) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (sram_ready || (cnt_q == TO_LAST)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. These are next values for the output flops, so each
    // registered output is valid during the state it belongs to.
    // -------------------------------------------------------------------------
    always_comb begin
        load_cmd     = (state_q == S_IDLE) && pick_valid;
        enter_done   = (state_q == S_WAIT) && (state_d == S_DONE);
        rdata_we     = (state_q == S_WAIT) && sram_ready && sram_rw_q;
        sram_start_d = load_cmd;
        req_ready_d  = '0;
        req_err_d    = '0;
        cnt_d        = cnt_q;

        if (enter_done) begin
            req_ready_d[grant_q] = 1'b1;
            req_err_d[grant_q]   = ~sram_ready;
        end

        if (state_q == S_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Command / bookkeeping registers. The command is captured only at the
    // IDLE grant, so later changes on the granted client's inputs have no
    // effect until the next transaction.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q      <= '0;
            last_grant_q <= LAST_INIT;
            cnt_q        <= '0;
            sram_start_q <= 1'b0;
            sram_rw_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_data_q  <= '0;
            req_ready_q  <= '0;
            req_err_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            sram_start_q <= sram_start_d;
            req_ready_q  <= req_ready_d;
            req_err_q    <= req_err_d;
            if (load_cmd) begin
                grant_q     <= pick_idx;
                sram_rw_q   <= req_rw[pick_idx];
                sram_addr_q <= addr_arr[pick_idx];
                sram_data_q <= wdata_arr[pick_idx];
            end
            if (enter_done) begin
                last_grant_q <= grant_q;
            end
        end
    end

    assign sram_start = sram_start_q;
    assign sram_rw    = sram_rw_q;
    assign sram_addr  = sram_addr_q;
    assign sram_data  = sram_data_q;
    assign req_ready  = req_ready_q;
    assign req_err    = req_err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed bench for sram_arbiter. Two four-client instances with TIMEOUT=8:
// u_rr is round-robin, u_fp is fixed priority. Request address/data/rw buses
// and sram_data_out are shared; each instance has its own req_start and
// sram_ready. Inputs change and outputs are sampled 1 time unit after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  start_rr, start_fp, req_rw;
    logic [63:0] req_addr, req_wdata;
    logic [15:0] sram_data_out;
    logic        ready_rr, ready_fp;

    logic [3:0]  rdy_rr, err_rr, rdy_fp, err_fp;
    logic [63:0] rdata_rr, rdata_fp;
    logic        ss_rr, srw_rr, ss_fp, srw_fp;
    logic [15:0] saddr_rr, sdata_rr, saddr_fp, sdata_fp;

    int tot = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sram_arbiter #(.NUM_CLIENTS(4), .ADDR_W(16), .DATA_W(16),
                   .FIXED_PRIORITY(0), .TIMEOUT(8)) u_rr (
        .clk(clk), .rst(rst),
        .req_start(start_rr), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rdy_rr), .req_err(err_rr), .req_rdata(rdata_rr),
        .sram_start(ss_rr), .sram_rw(srw_rr), .sram_addr(saddr_rr), .sram_data(sdata_rr),
        .sram_data_out(sram_data_out), .sram_ready(ready_rr)
    );

    sram_arbiter #(.NUM_CLIENTS(4), .ADDR_W(16), .DATA_W(16),
                   .FIXED_PRIORITY(1), .TIMEOUT(8)) u_fp (
        .clk(clk), .rst(rst),
        .req_start(start_fp), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rdy_fp), .req_err(err_fp), .req_rdata(rdata_fp),
        .sram_start(ss_fp), .sram_rw(srw_fp), .sram_addr(saddr_fp), .sram_data(sdata_fp),
        .sram_data_out(sram_data_out), .sram_ready(ready_fp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until the selected instance shows sram_start, at most 20 cycles.
    task automatic wait_start(input bit fp, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((fp ? ss_fp : ss_rr) !== 1'b1) && (n < 20));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start_rr = '0; start_fp = '0; req_rw = '0;
        req_addr = '0; req_wdata = '0; sram_data_out = 16'hDEAD;
        ready_rr = 1'b0; ready_fp = 1'b0;
        repeat (3) step();
        tot++; if (rdy_rr !== 4'h0) begin bad++; $display("FAIL reset_ready got=%h want=0", rdy_rr); end
        tot++; if (err_rr !== 4'h0) begin bad++; $display("FAIL reset_err got=%h want=0", err_rr); end
        tot++; if (rdata_rr !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata_rr); end
        tot++; if ({ss_rr, srw_rr, saddr_rr, sdata_rr} !== 34'h0) begin bad++;
            $display("FAIL reset_sram got=%b/%b/%h/%h want=0", ss_rr, srw_rr, saddr_rr, sdata_rr); end
        tot++; if ({rdy_fp, err_fp, ss_fp} !== 9'h0) begin bad++;
            $display("FAIL reset_fp got=%h/%h/%b want=0", rdy_fp, err_fp, ss_fp); end
        rst = 1'b0;
        step();
        $display("test_reset: done");
    endtask

    task automatic test_single_read();
        int n;
        req_rw = 4'b0010;
        req_addr[16 +: 16] = 16'h0040;
        sram_data_out = 16'hDEAD;
        start_rr = 4'b0010;
        wait_start(1'b0, n);
        tot++; if (n !== 1) begin bad++; $display("FAIL read_latency got=%0d want=1", n); end
        tot++; if (saddr_rr !== 16'h0040 || srw_rr !== 1'b1) begin bad++;
            $display("FAIL read_cmd got=%h/%b want=0040/1", saddr_rr, srw_rr); end
        step();
        tot++; if (ss_rr !== 1'b0 || rdy_rr !== 4'h0) begin bad++;
            $display("FAIL read_strobe got=%b/%h want=0/0", ss_rr, rdy_rr); end
        step();
        step();
        ready_rr = 1'b1; sram_data_out = 16'hBEEF;
        step();
        ready_rr = 1'b0; sram_data_out = 16'hDEAD;
        tot++; if (rdy_rr !== 4'b0010 || err_rr !== 4'h0) begin bad++;
            $display("FAIL read_done got=%h/%h want=2/0", rdy_rr, err_rr); end
        start_rr = 4'b0000;
        step();
        tot++; if (rdy_rr !== 4'h0) begin bad++; $display("FAIL read_pulse got=%h want=0", rdy_rr); end
        tot++; if (rdata_rr[16 +: 16] !== 16'hBEEF) begin bad++;
            $display("FAIL read_rdata1 got=%h want=beef", rdata_rr[16 +: 16]); end
        tot++; if (rdata_rr[0 +: 16] !== 16'h0000) begin bad++;
            $display("FAIL read_rdata0 got=%h want=0000", rdata_rr[0 +: 16]); end
        tot++; if (saddr_rr !== 16'h0040) begin bad++; $display("FAIL read_hold got=%h want=0040", saddr_rr); end
        $display("test_single_read: done");
    endtask

    task automatic test_round_robin();
        int n, prev, exp;
        do_reset();
        req_rw = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*16 +: 16]  = 16'h0100 + 16'(i);
            req_wdata[i*16 +: 16] = 16'hA000 + 16'(i);
        end
        start_rr = 4'hF;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            exp = k % 4;
            wait_start(1'b0, n);
            tot++; if (saddr_rr !== 16'h0100 + 16'(exp) || sdata_rr !== 16'hA000 + 16'(exp)) begin bad++;
                $display("FAIL rr_grant k=%0d got=%h/%h want client %0d", k, saddr_rr, sdata_rr, exp); end
            if (k > 0) begin
                tot++; if (cyc - prev !== 4) begin bad++;
                    $display("FAIL rr_spacing k=%0d got=%0d want=4", k, cyc - prev); end
            end
            prev = cyc;
            step();
            ready_rr = 1'b1;
            step();
            ready_rr = 1'b0;
            tot++; if (rdy_rr !== 4'(1 << exp)) begin bad++;
                $display("FAIL rr_ready k=%0d got=%h want=%h", k, rdy_rr, 4'(1 << exp)); end
            if (k == 4) start_rr = 4'h0;
            $display("test_round_robin: txn %0d client %0d", k, exp);
        end
        step();
        step();
    endtask

    task automatic test_fixed_priority();
        int n;
        start_fp = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            wait_start(1'b1, n);
            tot++; if (saddr_fp !== 16'h0100) begin bad++;
                $display("FAIL fp_grant k=%0d got=%h want=0100", k, saddr_fp); end
            step();
            ready_fp = 1'b1;
            step();
            ready_fp = 1'b0;
            tot++; if (rdy_fp !== 4'b0001) begin bad++;
                $display("FAIL fp_ready k=%0d got=%h want=1", k, rdy_fp); end
            if (k == 2) start_fp = 4'h0;
            $display("test_fixed_priority: txn %0d", k);
        end
        step();
        step();
        tot++; if (rdy_fp !== 4'h0) begin bad++; $display("FAIL fp_idle got=%h want=0", rdy_fp); end
    endtask

    task automatic test_timeout();
        int n;
        // Client 2 read, SRAM never answers: abort 9 cycles after sram_start.
        req_rw = 4'b1110;
        req_addr[32 +: 16] = 16'h0200;
        sram_data_out = 16'hDEAD;
        start_rr = 4'b0100;
        wait_start(1'b0, n);
        tot++; if (n !== 1 || saddr_rr !== 16'h0200) begin bad++;
            $display("FAIL to_issue got=%0d/%h want=1/0200", n, saddr_rr); end
        n = 0;
        do begin step(); n++; end while (rdy_rr === 4'h0 && n < 30);
        tot++; if (n !== 9) begin bad++; $display("FAIL to_latency got=%0d want=9", n); end
        tot++; if (rdy_rr !== 4'b0100 || err_rr !== 4'b0100) begin bad++;
            $display("FAIL to_flags got=%h/%h want=4/4", rdy_rr, err_rr); end
        start_rr = 4'h0;
        step();
        tot++; if (rdata_rr[32 +: 16] !== 16'h0000 || err_rr !== 4'h0) begin bad++;
            $display("FAIL to_rdata got=%h/%h want=0000/0", rdata_rr[32 +: 16], err_rr); end
        // Ready on the last allowed WAIT cycle still counts as success.
        req_addr[16 +: 16] = 16'h0041;
        start_rr = 4'b0010;
        wait_start(1'b0, n);
        repeat (8) step();
        ready_rr = 1'b1; sram_data_out = 16'h7777;
        step();
        ready_rr = 1'b0; sram_data_out = 16'hDEAD;
        tot++; if (rdy_rr !== 4'b0010 || err_rr !== 4'h0) begin bad++;
            $display("FAIL to_edge got=%h/%h want=2/0", rdy_rr, err_rr); end
        start_rr = 4'h0;
        step();
        tot++; if (rdata_rr[16 +: 16] !== 16'h7777) begin bad++;
            $display("FAIL to_edge_rdata got=%h want=7777", rdata_rr[16 +: 16]); end
        // Following request served normally.
        req_addr[48 +: 16] = 16'h0300;
        start_rr = 4'b1000;
        wait_start(1'b0, n);
        step();
        ready_rr = 1'b1; sram_data_out = 16'h5A5A;
        step();
        ready_rr = 1'b0; sram_data_out = 16'hDEAD;
        tot++; if (rdy_rr !== 4'b1000 || err_rr !== 4'h0) begin bad++;
            $display("FAIL to_next got=%h/%h want=8/0", rdy_rr, err_rr); end
        start_rr = 4'h0;
        step();
        tot++; if (rdata_rr[48 +: 16] !== 16'h5A5A) begin bad++;
            $display("FAIL to_next_rdata got=%h want=5a5a", rdata_rr[48 +: 16]); end
        $display("test_timeout: done");
    endtask

    task automatic test_stray_ready();
        int n;
        int stray_hits;
        stray_hits = 0;
        ready_rr = 1'b1;
        repeat (3) begin
            step();
            if (rdy_rr !== 4'h0) stray_hits++;
        end
        ready_rr = 1'b0;
        step();
        if (rdy_rr !== 4'h0) stray_hits++;
        tot++; if (stray_hits !== 0) begin bad++;
            $display("FAIL stray_ready got=%0d pulses want=0", stray_hits); end
        req_rw[0] = 1'b0;
        req_addr[0 +: 16] = 16'h00FF;
        req_wdata[0 +: 16] = 16'h1234;
        start_rr = 4'b0001;
        wait_start(1'b0, n);
        tot++; if (saddr_rr !== 16'h00FF || sdata_rr !== 16'h1234 || srw_rr !== 1'b0) begin bad++;
            $display("FAIL wr_cmd got=%h/%h/%b want=00ff/1234/0", saddr_rr, sdata_rr, srw_rr); end
        req_wdata[0 +: 16] = 16'h9999;
        step();
        step();
        step();
        tot++; if (rdy_rr !== 4'h0) begin bad++; $display("FAIL wr_early got=%h want=0", rdy_rr); end
        ready_rr = 1'b1; sram_data_out = 16'hFFFF;
        step();
        ready_rr = 1'b0; sram_data_out = 16'hDEAD;
        tot++; if (rdy_rr !== 4'b0001 || err_rr !== 4'h0) begin bad++;
            $display("FAIL wr_done got=%h/%h want=1/0", rdy_rr, err_rr); end
        tot++; if (sdata_rr !== 16'h1234) begin bad++; $display("FAIL wr_hold got=%h want=1234", sdata_rr); end
        start_rr = 4'h0;
        step();
        tot++; if (rdata_rr[0 +: 16] !== 16'h0000) begin bad++;
            $display("FAIL wr_rdata got=%h want=0000", rdata_rr[0 +: 16]); end
        $display("test_stray_ready: done");
    endtask

    task automatic test_reset_mid_wait();
        int n;
        start_rr = 4'b0100;
        wait_start(1'b0, n);
        step();
        rst = 1'b1;
        #1;
        tot++; if ({ss_rr, srw_rr, saddr_rr, sdata_rr} !== 34'h0) begin bad++;
            $display("FAIL mid_rst_sram got=%b/%b/%h/%h want=0", ss_rr, srw_rr, saddr_rr, sdata_rr); end
        tot++; if (rdata_rr !== 64'h0 || rdy_rr !== 4'h0) begin bad++;
            $display("FAIL mid_rst_out got=%h/%h want=0/0", rdata_rr, rdy_rr); end
        start_rr = 4'b0101;
        ready_rr = 1'b1;
        step();
        step();
        ready_rr = 1'b0;
        tot++; if (rdy_rr !== 4'h0) begin bad++; $display("FAIL mid_rst_ready got=%h want=0", rdy_rr); end
        rst = 1'b0;
        wait_start(1'b0, n);
        tot++; if (n !== 1 || saddr_rr !== 16'h00FF) begin bad++;
            $display("FAIL mid_rst_first got=%0d/%h want=1/00ff", n, saddr_rr); end
        step();
        ready_rr = 1'b1;
        step();
        ready_rr = 1'b0;
        tot++; if (rdy_rr !== 4'b0001) begin bad++; $display("FAIL mid_rst_done got=%h want=1", rdy_rr); end
        start_rr = 4'h0;
        step();
        $display("test_reset_mid_wait: done");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_timeout();
        test_stray_ready();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
